// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: states, opcodes and datapath select codes.
// The JAL state exists only when MULTICYCLE_CONTROL_JAL_EN is defined.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_INIT,
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_BRANCH,
        S_JUMP
`ifdef MULTICYCLE_CONTROL_JAL_EN
        , S_JAL
`endif
    } state_t;

    // One-hot opcode class; jal is always reported, acceptance is decided by the FSM.
    typedef struct packed {
        logic r;
        logic alu_i;
        logic lw;
        logic sw;
        logic br;
        logic j;
        logic jal;
        logic illegal;
    } op_class_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [2:0] ALU_PCADD = 3'b000;
    localparam logic [2:0] ALU_ADDR  = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b100;
    localparam logic [2:0] ALU_ADDI  = 3'b110;
    localparam logic [2:0] ALU_ANDI  = 3'b011;
    localparam logic [2:0] ALU_ORI   = 3'b101;
    localparam logic [2:0] ALU_LUI   = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b111;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    function automatic logic [2:0] alu_i_op(input logic [5:0] op);
        case (op)
            OP_ANDI: alu_i_op = ALU_ANDI;
            OP_ORI:  alu_i_op = ALU_ORI;
            OP_LUI:  alu_i_op = ALU_LUI;
            default: alu_i_op = ALU_ADDI;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_opcode_class.sv
// Combinational opcode classifier shared by the sequencer's next-state and output logic.
// Independent of MULTICYCLE_CONTROL_JAL_EN: 0x03 is always flagged as jal.
module opcode_class
    import multicycle_control_pkg::*;
(
    input  logic [5:0] i_op,
    output logic [7:0] o_class
);

    op_class_t w_cls;

    always_comb begin
        w_cls = '0;
        case (i_op)
            OP_RTYPE:                         w_cls.r       = 1'b1;
            OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: w_cls.alu_i   = 1'b1;
            OP_LW:                            w_cls.lw      = 1'b1;
            OP_SW:                            w_cls.sw      = 1'b1;
            OP_BEQ, OP_BNE:                   w_cls.br      = 1'b1;
            OP_J:                             w_cls.j       = 1'b1;
            OP_JAL:                           w_cls.jal     = 1'b1;
            default:                          w_cls.illegal = 1'b1;
        endcase
    end

    assign o_class = w_cls;

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control sequencer with a mem_ready wait-state handshake.
// Define MULTICYCLE_CONTROL_JAL_EN to accept JAL (opcode 0x03); otherwise it decodes as illegal.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OP,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCondEQ,
    output logic       PCWriteCondNE,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       illegal_op
);

    state_t     r_state;
    logic [7:0] w_cls_bits;
    op_class_t  w_cls;
    logic       w_bad;

    opcode_class u_opcode_class (
        .i_op    (OP),
        .o_class (w_cls_bits)
    );

    assign w_cls = w_cls_bits;

`ifdef MULTICYCLE_CONTROL_JAL_EN
    assign w_bad = w_cls.illegal;
`else
    assign w_bad = w_cls.illegal | w_cls.jal;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_INIT;
        end else begin
            case (r_state)
                S_INIT:      r_state <= S_FETCH;
                S_FETCH:     if (mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    if (w_cls.r)                  r_state <= S_EXEC_R;
                    else if (w_cls.alu_i)         r_state <= S_EXEC_I;
                    else if (w_cls.lw | w_cls.sw) r_state <= S_MEM_ADDR;
                    else if (w_cls.br)            r_state <= S_BRANCH;
                    else if (w_cls.j)             r_state <= S_JUMP;
`ifdef MULTICYCLE_CONTROL_JAL_EN
                    else if (w_cls.jal)           r_state <= S_JAL;
`endif
                    else                          r_state <= S_FETCH;
                end
                S_EXEC_R, S_EXEC_I: r_state <= S_ALU_WB;
                S_MEM_ADDR:  r_state <= w_cls.lw ? S_MEM_READ : S_MEM_WRITE;
                S_MEM_READ:  if (mem_ready) r_state <= S_MEM_WB;
                S_MEM_WRITE: if (mem_ready) r_state <= S_FETCH;
                default:     r_state <= S_FETCH;
            endcase
        end
    end

    // Moore decode; only FETCH loads and MEM_WRITE completion look at mem_ready.
    always_comb begin
        PCWrite       = 1'b0;
        PCWriteCondEQ = 1'b0;
        PCWriteCondNE = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegDst        = REGDST_RT;
        MemtoReg      = M2R_ALUOUT;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = SRCB_REG;
        ALUOp         = ALU_PCADD;
        PCSource      = PCSRC_ALU;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB    = SRCB_IMM_SH;
                illegal_op = w_bad;
                instr_done = w_bad;
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_RTYPE;
            end
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = alu_i_op(OP);
            end
            S_ALU_WB: begin
                RegWrite   = 1'b1;
                RegDst     = w_cls.r ? REGDST_RD : REGDST_RT;
                instr_done = 1'b1;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALU_ADDR;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite   = 1'b1;
                MemtoReg   = M2R_MDR;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
            end
            S_BRANCH: begin
                ALUSrcA       = 1'b1;
                ALUOp         = ALU_SUB;
                PCSource      = PCSRC_ALUOUT;
                PCWriteCondEQ = (OP == OP_BEQ);
                PCWriteCondNE = (OP == OP_BNE);
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_JUMP;
                instr_done = 1'b1;
            end
`ifdef MULTICYCLE_CONTROL_JAL_EN
            S_JAL: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_JUMP;
                RegWrite   = 1'b1;
                RegDst     = REGDST_RA;
                MemtoReg   = M2R_PC;
                instr_done = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule
